axi_rd_responder: RTL and testbench
===================================

Name: axi_rd_responder

Overview:
- AXI4 read-channel responder (memory model / DDR-side slave) for the prefetcher's master port (m_ar_*, m_r_*).
- Accepts AR requests into an in-order queue.
- After a fixed latency, returns each request as an R burst carrying the request's ID, a deterministic address-derived data pattern, and LAST on the final beat.
- Used in benches to close the prefetch loop, and as a reference target for prefetch traffic.

Parameters:
- ADDR_BITS, 64, AR address width.
- BURST_LEN_WIDTH, 8, AR length width; beats per burst = len+1.
- TID_WIDTH, 8, AR/R ID width.
- DATA_WIDTH, 64, R data width.
- LOG_QUEUE_SIZE, 3, AR queue depth = 2^LOG_QUEUE_SIZE.
- READ_LATENCY, 4, extra wait cycles before first beat; 0 is legal.
- BYTES_PER_BEAT, 8, address increment per beat (INCR bursts only).

Ports:
- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- en  in  1  when 0, no new burst is started; an active burst still completes.
- ar_valid  in  1  AR request valid.
- ar_ready  out  1  AR queue can accept.
- ar_addr  in  ADDR_BITS  burst start address.
- ar_len  in  BURST_LEN_WIDTH  beats-1.
- ar_id  in  TID_WIDTH  transaction ID.
- r_valid  out  1  R beat valid.
- r_ready  in  1  R beat accepted.
- r_data  out  DATA_WIDTH  beat data.
- r_id  out  TID_WIDTH  ID of the active burst.
- r_last  out  1  final beat of the burst.
- q_count  out  LOG_QUEUE_SIZE+1  queued requests (excludes the active burst).

Behaviour:
- Reset (async, immediate):
  - queue empty, q_count=0, ar_ready=1.
  - r_valid=0, r_last=0, r_data=0, r_id=0, FSM=IDLE.
  - A reset mid-burst drops r_valid in the same cycle and discards all queued and active requests.
- AR queue (FIFO):
  - ar_ready = (q_count != 2^LOG_QUEUE_SIZE), derived from registered count.
  - Push on ar_valid&&ar_ready, storing {addr,len,id}.
  - Pop occurs in IDLE when the FSM starts a burst.
  - Push and pop in the same cycle leave q_count unchanged.
  - When full, ar_ready=0; a pop in that cycle re-raises ar_ready only from the next cycle.
  - Pointers wrap modulo depth.
- FSM IDLE -> WAIT -> BURST -> IDLE:
  - IDLE: if en && q_count!=0, pop head into active registers (addr, len, id, beat=0), load lat_cnt=READ_LATENCY, go to WAIT.
  - WAIT: if lat_cnt==0, go to BURST; otherwise decrement.
  - BURST: r_valid=1 and r_id=active id.
  - Beat data: r_data = (active_addr + beat*BYTES_PER_BEAT) mod 2^ADDR_BITS, zero-extended or truncated (low bits) to DATA_WIDTH.
  - r_last = (beat == active_len).
  - On r_valid&&r_ready: if r_last, go to IDLE; else beat++.
- Latency: with an idle responder and en=1, an AR handshake at edge E gives the first r_valid after edge E+2+READ_LATENCY. Consecutive bursts have one idle cycle between them (IDLE state).
- Backpressure: while r_valid=1 && r_ready=0, r_data, r_id and r_last hold stable; r_valid never drops until the handshake.
- Ordering: strictly in AR-acceptance order regardless of ID.
- en:
  - Sampled only in IDLE.
  - Deasserting in WAIT or BURST has no effect on the active burst.
  - AR acceptance is independent of en.
- ar_len=0 gives a single beat with r_last=1.
- ar_len=2^BURST_LEN_WIDTH-1 gives the full beat count; the beat counter is BURST_LEN_WIDTH wide and never overflows.

Test Plan:
- Reset, then single AR (addr=0xdeadbeef, len=3, id=3), r_ready=1, READ_LATENCY=4:
  - ar_ready=1 at handshake.
  - r_valid first high after edge E+6.
  - 4 beats, data 0xdeadbeef, 0xdeadbef7, 0xdeadbeff, 0xdeadbf07, all r_id=3.
  - r_last only on beat 4.
- Three back-to-back ARs (addr 0xdeadbeef + i*64, len=4, id=3):
  - queue accepts all three; q_count peaks at 2.
  - Bursts return in order, 5 beats each, with exactly one idle cycle between bursts.
- Fill queue with 9 ARs while en=0 (depth 8):
  - ar_ready drops after the 8th; q_count=8.
  - Raising en drains the queue; ar_ready returns one cycle after the first pop.
- Backpressure: toggle r_ready 0/1 every cycle during len=2 burst:
  - each beat is held stable while r_ready=0.
  - total 3 handshakes, no beat skipped or repeated.
- Address wrap: addr=0xFFFFFFFFFFFFFFF8, len=1 gives beats 0xFFFFFFFFFFFFFFF8 then 0x0.
- Assert resetN=0 mid-burst (beat 2 of 5, queue holding 2): r_valid=0 immediately; after release, q_count=0 and no residual beats.

Source files
------------

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder: queues AR requests in order and, after a fixed
// latency, replays each one as an R burst whose data is the beat address.
module axi_rd_responder #(
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 64,
  parameter int LOG_QUEUE_SIZE  = 3,
  parameter int READ_LATENCY    = 4,
  parameter int BYTES_PER_BEAT  = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       en,
  input  logic                       ar_valid,
  output logic                       ar_ready,
  input  logic [ADDR_BITS-1:0]       ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] ar_len,
  input  logic [TID_WIDTH-1:0]       ar_id,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic [TID_WIDTH-1:0]       r_id,
  output logic                       r_last,
  output logic [LOG_QUEUE_SIZE:0]    q_count
);

  localparam int DEPTH = 1 << LOG_QUEUE_SIZE;
  // Latency counter must hold READ_LATENCY; keep at least one bit so 0 is legal.
  localparam int LAT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);
  localparam logic [LOG_QUEUE_SIZE:0] FULL_COUNT = {1'b1, {LOG_QUEUE_SIZE{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_e;

  // Request storage
  logic [ADDR_BITS-1:0]       memAddr [DEPTH];
  logic [BURST_LEN_WIDTH-1:0] memLen  [DEPTH];
  logic [TID_WIDTH-1:0]       memId   [DEPTH];

  logic [LOG_QUEUE_SIZE-1:0] wrPtr_q, wrPtr_d;
  logic [LOG_QUEUE_SIZE-1:0] rdPtr_q, rdPtr_d;
  logic [LOG_QUEUE_SIZE:0]   count_q, count_d;

  state_e                     state_q, state_d;
  logic [LAT_W-1:0]           latCnt_q, latCnt_d;
  logic [BURST_LEN_WIDTH-1:0] beat_q, beat_d;
  logic [ADDR_BITS-1:0]       actAddr_q, actAddr_d;
  logic [BURST_LEN_WIDTH-1:0] actLen_q, actLen_d;
  logic [TID_WIDTH-1:0]       actId_q, actId_d;

  logic                 push;
  logic                 pop;
  logic                 lastBeat;
  logic [ADDR_BITS-1:0] beatAddr;

  // ar_ready comes from the registered count, so a pop while full only
  // re-opens the queue on the following cycle.
  assign ar_ready = (count_q != FULL_COUNT);
  assign push     = ar_valid && ar_ready;
  assign pop      = (state_q == S_IDLE) && en && (count_q != '0);
  assign q_count  = count_q;

  assign lastBeat = (beat_q == actLen_q);
  assign beatAddr = actAddr_q + (ADDR_BITS'(beat_q) * ADDR_BITS'(BYTES_PER_BEAT));

  // Outputs are zero outside a burst so reset and idle look identical.
  assign r_valid = (state_q == S_BURST);
  assign r_data  = r_valid ? DATA_WIDTH'(beatAddr) : '0;
  assign r_id    = r_valid ? actId_q : '0;
  assign r_last  = r_valid && lastBeat;

  // Request payload RAM; contents are only meaningful under the count.
  always_ff @(posedge clk) begin
    if (push) begin
      memAddr[wrPtr_q] <= ar_addr;
      memLen[wrPtr_q]  <= ar_len;
      memId[wrPtr_q]   <= ar_id;
    end
  end

  // Queue pointer and occupancy next-state; pointers wrap at the depth.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Burst FSM: IDLE pops a request, WAIT burns the latency, BURST emits beats.
  always_comb begin
    state_d   = state_q;
    latCnt_d  = latCnt_q;
    beat_d    = beat_q;
    actAddr_d = actAddr_q;
    actLen_d  = actLen_q;
    actId_d   = actId_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          actAddr_d = memAddr[rdPtr_q];
          actLen_d  = memLen[rdPtr_q];
          actId_d   = memId[rdPtr_q];
          beat_d    = '0;
          latCnt_d  = LAT_LOAD;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (latCnt_q == '0) begin
          state_d = S_BURST;
        end else begin
          latCnt_d = latCnt_q - 1'b1;
        end
      end
      S_BURST: begin
        if (r_ready) begin
          if (lastBeat) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and queue registers; reset discards queued and active requests.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      latCnt_q  <= '0;
      beat_q    <= '0;
      actAddr_q <= '0;
      actLen_q  <= '0;
      actId_q   <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      latCnt_q  <= latCnt_d;
      beat_q    <= beat_d;
      actAddr_q <= actAddr_d;
      actLen_q  <= actLen_d;
      actId_q   <= actId_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed scenarios plus a randomized phase,
// scored against an expected-beat queue built from each accepted AR.
module tb_axi_rd_responder;

  localparam int RL  = 4;
  localparam int BPB = 8;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        en = 1'b0;
  logic        ar_valid = 1'b0;
  logic        r_ready = 1'b0;
  logic [63:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [7:0]  ar_id = '0;
  logic        ar_ready;
  logic        r_valid;
  logic        r_last;
  logic [63:0] r_data;
  logic [7:0]  r_id;
  logic [3:0]  q_count;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  id;
    logic        last;
  } beat_t;

  beat_t expBeats[$];
  beat_t heldBeat;

  int total = 0;
  int bad = 0;
  int cycleNo = 0;
  int beatsTaken = 0;
  int arAcceptCycle = 0;
  int firstValidCycle = -1;
  int lowRun = 0;
  int peak = 0;
  int base = 0;
  bit arDone = 1'b0;
  bit holdPending = 1'b0;
  bit prevValid = 1'b0;
  bit afterLast = 1'b0;
  bit gapCheck = 1'b0;

  axi_rd_responder dut (
    .clk      (clk),
    .resetN   (resetN),
    .en       (en),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .ar_addr  (ar_addr),
    .ar_len   (ar_len),
    .ar_id    (ar_id),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_data   (r_data),
    .r_id     (r_id),
    .r_last   (r_last),
    .q_count  (q_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, score, then step past the rising edge.
  task automatic cycle();
    beat_t b;
    @(negedge clk);
    if (holdPending) begin
      checkOutput("hold_valid", 64'(r_valid), 64'd1);
      checkOutput("hold_data", r_data, heldBeat.data);
      checkOutput("hold_id", 64'(r_id), 64'(heldBeat.id));
      checkOutput("hold_last", 64'(r_last), 64'(heldBeat.last));
    end
    if (!r_valid) begin
      lowRun++;
    end else begin
      if (!prevValid && gapCheck && afterLast)
        checkOutput("burst_gap", 64'(lowRun), 64'(RL + 2));
      if (!prevValid && firstValidCycle < 0)
        firstValidCycle = cycleNo;
      lowRun = 0;
      afterLast = 1'b0;
    end
    if (int'(q_count) > peak) peak = int'(q_count);
    if (ar_valid && ar_ready) begin
      for (int i = 0; i <= int'(ar_len); i++) begin
        b.data = ar_addr + 64'(i) * 64'(BPB);
        b.id   = ar_id;
        b.last = (i == int'(ar_len));
        expBeats.push_back(b);
      end
      arDone = 1'b1;
      arAcceptCycle = cycleNo;
    end
    if (r_valid && r_ready) begin
      if (expBeats.size() == 0) begin
        checkOutput("unexpected_beat", 64'(r_valid), 64'd0);
      end else begin
        b = expBeats.pop_front();
        checkOutput("r_data", r_data, b.data);
        checkOutput("r_id", 64'(r_id), 64'(b.id));
        checkOutput("r_last", 64'(r_last), 64'(b.last));
      end
      beatsTaken++;
      if (r_last) afterLast = 1'b1;
    end
    holdPending = r_valid && !r_ready;
    heldBeat.data = r_data;
    heldBeat.id   = r_id;
    heldBeat.last = r_last;
    prevValid = r_valid;
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  // Present one AR and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id);
    ar_addr = addr;
    ar_len = len;
    ar_id = id;
    ar_valid = 1'b1;
    arDone = 1'b0;
    for (int k = 0; k < 100 && !arDone; k++) cycle();
    checkOutput("ar_accept", 64'(arDone), 64'd1);
    ar_valid = 1'b0;
  endtask

  // Run until every expected beat has been returned and the responder is idle.
  task automatic drain(input bit toggle);
    en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (expBeats.size() == 0 && !r_valid && q_count == 4'd0 && !ar_valid) break;
      r_ready = toggle ? ~r_ready : 1'b1;
      cycle();
    end
    checkOutput("drain_empty", 64'(expBeats.size()), 64'd0);
    checkOutput("drain_qcount", 64'(q_count), 64'd0);
    r_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    resetN = 1'b0;
    cycle();
    cycle();
    checkOutput("rst_ar_ready", 64'(ar_ready), 64'd1);
    checkOutput("rst_q_count", 64'(q_count), 64'd0);
    checkOutput("rst_r_valid", 64'(r_valid), 64'd0);
    checkOutput("rst_r_last", 64'(r_last), 64'd0);
    checkOutput("rst_r_data", r_data, 64'd0);
    checkOutput("rst_r_id", 64'(r_id), 64'd0);
    resetN = 1'b1;
    cycle();

    // Single burst latency and data
    $display("[TB] single burst");
    en = 1'b1;
    r_ready = 1'b1;
    firstValidCycle = -1;
    base = beatsTaken;
    checkOutput("t1_ar_ready", 64'(ar_ready), 64'd1);
    applyStimulus(64'hdeadbeef, 8'd3, 8'd3);
    drain(1'b0);
    checkOutput("t1_latency", 64'(firstValidCycle - arAcceptCycle - 1), 64'(RL + 2));
    checkOutput("t1_beats", 64'(beatsTaken - base), 64'd4);

    // Three back-to-back bursts
    $display("[TB] back-to-back bursts");
    peak = 0;
    gapCheck = 1'b1;
    afterLast = 1'b0;
    base = beatsTaken;
    for (int i = 0; i < 3; i++) applyStimulus(64'hdeadbeef + 64'(i * 64), 8'd4, 8'd3);
    drain(1'b0);
    gapCheck = 1'b0;
    checkOutput("t2_peak", 64'(peak), 64'd2);
    checkOutput("t2_beats", 64'(beatsTaken - base), 64'd15);

    // Fill the queue with en low
    $display("[TB] queue full");
    en = 1'b0;
    base = beatsTaken;
    for (int i = 0; i < 8; i++) applyStimulus(64'h1000 + 64'(i * 256), 8'd1, 8'(i));
    checkOutput("t3_full_ready", 64'(ar_ready), 64'd0);
    checkOutput("t3_full_count", 64'(q_count), 64'd8);
    ar_addr = 64'h9000;
    ar_len = 8'd1;
    ar_id = 8'd9;
    ar_valid = 1'b1;
    arDone = 1'b0;
    cycle();
    cycle();
    checkOutput("t3_ninth_blocked", 64'(arDone), 64'd0);
    en = 1'b1;
    checkOutput("t3_ready_before_pop", 64'(ar_ready), 64'd0);
    cycle();
    checkOutput("t3_ready_after_pop", 64'(ar_ready), 64'd1);
    checkOutput("t3_count_after_pop", 64'(q_count), 64'd7);
    cycle();
    checkOutput("t3_ninth_accepted", 64'(arDone), 64'd1);
    ar_valid = 1'b0;
    drain(1'b0);
    checkOutput("t3_beats", 64'(beatsTaken - base), 64'd18);

    // Backpressure with r_ready toggling every cycle
    $display("[TB] backpressure");
    base = beatsTaken;
    applyStimulus(64'h2000, 8'd2, 8'h55);
    r_ready = 1'b0;
    drain(1'b1);
    checkOutput("t4_handshakes", 64'(beatsTaken - base), 64'd3);

    // Address wrap and longest burst
    $display("[TB] wrap and max length");
    base = beatsTaken;
    applyStimulus(64'hFFFFFFFFFFFFFFF8, 8'd1, 8'h21);
    applyStimulus(64'h4000, 8'd255, 8'h22);
    drain(1'b0);
    checkOutput("t5_beats", 64'(beatsTaken - base), 64'd258);

    // Reset in the middle of a burst
    $display("[TB] reset mid-burst");
    base = beatsTaken;
    for (int i = 0; i < 3; i++) applyStimulus(64'h5000 + 64'(i * 64), 8'd4, 8'(i + 1));
    for (int k = 0; k < 100 && beatsTaken < base + 1; k++) cycle();
    checkOutput("t6_mid_valid", 64'(r_valid), 64'd1);
    checkOutput("t6_mid_count", 64'(q_count), 64'd2);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(r_valid), 64'd0);
    checkOutput("t6_rst_count", 64'(q_count), 64'd0);
    checkOutput("t6_rst_ready", 64'(ar_ready), 64'd1);
    expBeats.delete();
    holdPending = 1'b0;
    prevValid = 1'b0;
    #10;
    resetN = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    checkOutput("t6_after_count", 64'(q_count), 64'd0);
    checkOutput("t6_after_valid", 64'(r_valid), 64'd0);

    // Randomized traffic
    $display("[TB] random traffic");
    arDone = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!ar_valid && $urandom_range(0, 2) == 0) begin
        ar_addr = {$urandom, $urandom};
        ar_len = 8'($urandom_range(0, 7));
        ar_id = 8'($urandom);
        ar_valid = 1'b1;
      end
      r_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      cycle();
      if (arDone) begin
        ar_valid = 1'b0;
        arDone = 1'b0;
      end
    end
    if (ar_valid) begin
      en = 1'b1;
      for (int k = 0; k < 500 && !arDone; k++) begin
        r_ready = 1'b1;
        cycle();
      end
      checkOutput("rand_last_ar", 64'(arDone), 64'd1);
      ar_valid = 1'b0;
    end
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
